// File: rtl/fbuf_clear_ctrl.sv
// Framebuffer clear controller: registers GPU writes through to BRAM port A
// and runs full-frame clear sweeps on reset and on GPU clear requests.
module fbuf_clear_ctrl #(
    parameter int                          FRAME_WIDTH_SCALED  = 640,
    parameter int                          FRAME_HEIGHT_SCALED = 480,
    parameter int                          FBUF_ADDR_WIDTH     = 19,
    parameter int                          FBUF_DATA_WIDTH     = 8,
    parameter logic [FBUF_DATA_WIDTH-1:0]  CLEAR_VALUE         = '0,
    parameter int                          CLEAR_ON_RESET      = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fbuf_en_wr,
    input  logic                       fbuf_wrea,
    input  logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
    input  logic                       fbuf_rst_req_n,
    output logic                       fbuf_rst_busy,
    output logic                       bram_en,
    output logic                       bram_we,
    output logic [FBUF_ADDR_WIDTH-1:0] bram_addr,
    output logic [FBUF_DATA_WIDTH-1:0] bram_din,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned                DEPTH     = FRAME_WIDTH_SCALED * FRAME_HEIGHT_SCALED;
    localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_ADDR = FBUF_ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_REL
    } state_t;

    state_t                     state_q, state_d;
    logic [FBUF_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                       busy_q, busy_d;
    logic                       en_q, en_d;
    logic                       we_q, we_d;
    logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [FBUF_DATA_WIDTH-1:0] din_q, din_d;
    logic [15:0]                drop_q, drop_d;

    logic gpu_wr;
    logic in_range;
    logic drop_inc;

    assign gpu_wr   = fbuf_en_wr & fbuf_wrea;
    assign in_range = (32'(fbuf_addr) < DEPTH);

    // Next-state and registered-output decode; GPU writes that cannot be
    // forwarded (out of range, or arriving while a clear owns the port) are counted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        en_d     = en_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        drop_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                en_d   = fbuf_en_wr;
                we_d   = gpu_wr;
                addr_d = fbuf_addr;
                din_d  = fbuf_data;
                if (!in_range) begin
                    en_d     = 1'b0;
                    we_d     = 1'b0;
                    drop_inc = gpu_wr;
                end
                // The access sampled with the request is still forwarded.
                if (!fbuf_rst_req_n) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                en_d     = 1'b1;
                we_d     = 1'b1;
                addr_d   = cnt_q;
                din_d    = CLEAR_VALUE;
                cnt_d    = cnt_q + 1'b1;
                drop_inc = gpu_wr;
                // Request level is ignored mid-sweep; only checked at the end.
                if (cnt_q == LAST_ADDR) begin
                    cnt_d = '0;
                    if (fbuf_rst_req_n) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_WAIT_REL;
                    end
                end
            end
            ST_WAIT_REL: begin
                en_d     = 1'b0;
                we_d     = 1'b0;
                drop_inc = gpu_wr;
                if (fbuf_rst_req_n) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
                we_d    = 1'b0;
            end
        endcase
        drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    // State and output registers; async reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            drop_q  <= drop_d;
        end
    end

    assign fbuf_rst_busy = busy_q;
    assign bram_en       = en_q;
    assign bram_we       = we_q;
    assign bram_addr     = addr_q;
    assign bram_din      = din_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_fbuf_clear_ctrl.sv
// Bench for fbuf_clear_ctrl: 8x4 frame (32 pixels), clear value A5.
// A transaction-level model predicts the BRAM port every cycle; directed
// scenarios add literal expectations on top.
module tb_fbuf_clear_ctrl;

    localparam int W = 8, H = 4, DEPTH = W * H, AW = 8, DW = 8;
    localparam logic [7:0] CV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fbuf_en_wr = 1'b0, fbuf_wrea = 1'b0, fbuf_rst_req_n = 1'b1;
    logic [AW-1:0] fbuf_addr = '0;
    logic [DW-1:0] fbuf_data = '0;
    logic          fbuf_rst_busy, bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [15:0]   drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fbuf_clear_ctrl #(
        .FRAME_WIDTH_SCALED(W), .FRAME_HEIGHT_SCALED(H),
        .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW),
        .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea),
        .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data),
        .fbuf_rst_req_n(fbuf_rst_req_n), .fbuf_rst_busy(fbuf_rst_busy),
        .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is "clears still owed" plus the next address; after it
    // the port is parked until the request is released.
    int         m_left = DEPTH, m_next = 0, m_drop = 0;
    bit         m_wait = 0, m_busy = 1, m_en = 0, m_we = 0;
    logic [7:0] m_addr = '0, m_din = '0;

    always @(posedge clk or negedge rst_n) begin
        bit wr;
        if (!rst_n) begin
            m_left = DEPTH; m_next = 0; m_wait = 0; m_busy = 1;
            m_en = 0; m_we = 0; m_addr = '0; m_din = '0; m_drop = 0;
        end else begin
            wr = fbuf_en_wr && fbuf_wrea;
            if (m_left > 0) begin
                m_en = 1; m_we = 1; m_addr = 8'(m_next); m_din = CV;
                m_next++; m_left--;
                if (wr) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
                if (m_left == 0) begin
                    if (fbuf_rst_req_n) m_busy = 0;
                    else m_wait = 1;
                end
            end else if (m_wait) begin
                m_en = 0; m_we = 0;
                if (wr) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
                if (fbuf_rst_req_n) begin m_wait = 0; m_busy = 0; end
            end else begin
                m_addr = fbuf_addr; m_din = fbuf_data;
                if (int'(fbuf_addr) < DEPTH) begin
                    m_en = fbuf_en_wr; m_we = wr;
                end else begin
                    m_en = 0; m_we = 0;
                    if (wr) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
                end
                if (!fbuf_rst_req_n) begin m_left = DEPTH; m_next = 0; m_busy = 1; end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", 32'(fbuf_rst_busy), 32'(m_busy));
        chk("bram_en", 32'(bram_en), 32'(m_en));
        chk("bram_we", 32'(bram_we), 32'(m_we));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (m_en) begin
            chk("bram_addr", 32'(bram_addr), 32'(m_addr));
            chk("bram_din", 32'(bram_din), 32'(m_din));
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (fbuf_rst_busy && n < 200) begin @(negedge clk); n++; end
        if (fbuf_rst_busy) chk({name, "_timeout"}, 32'(fbuf_rst_busy), 32'd0);
    endtask

    initial begin
        int n, clr, leak;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(fbuf_rst_busy), 32'd1);
        chk("rst_en", 32'(bram_en), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // 1: sweep after reset, busy for exactly DEPTH cycles
        rst_n = 1'b1;
        n = 0;
        while (fbuf_rst_busy && n < 100) begin n++; @(negedge clk); end
        chk("t1_busy_cycles", 32'(n), 32'd32);
        chk("t1_last_addr", 32'(bram_addr), 32'd31);
        chk("t1_last_din", 32'(bram_din), 32'hA5);
        @(negedge clk);
        chk("t1_en_after", 32'(bram_en), 32'd0);

        // 2: pass-through write then read
        fbuf_en_wr = 1; fbuf_wrea = 1; fbuf_addr = 8'd5; fbuf_data = 8'hE3;
        @(negedge clk);
        chk("t2_en", 32'(bram_en), 32'd1);
        chk("t2_we", 32'(bram_we), 32'd1);
        chk("t2_addr", 32'(bram_addr), 32'd5);
        chk("t2_din", 32'(bram_din), 32'hE3);
        fbuf_wrea = 0; fbuf_addr = 8'd6;
        @(negedge clk);
        chk("t2_rd_en", 32'(bram_en), 32'd1);
        chk("t2_rd_we", 32'(bram_we), 32'd0);

        // 3: out-of-range write dropped
        fbuf_wrea = 1; fbuf_addr = 8'd32; fbuf_data = 8'h11;
        @(negedge clk);
        chk("t3_en", 32'(bram_en), 32'd0);
        chk("t3_drop", 32'(drop_cnt), 32'd1);
        fbuf_en_wr = 0; fbuf_wrea = 0;

        // 4: request held 40 cycles, 3 GPU writes mid-sweep
        clr = 0; leak = 0;
        for (int i = 0; i < 40; i++) begin
            fbuf_rst_req_n = 0;
            if (i == 5 || i == 10 || i == 15) begin
                fbuf_en_wr = 1; fbuf_wrea = 1; fbuf_addr = 8'd7; fbuf_data = 8'h3C;
            end else begin
                fbuf_en_wr = 0; fbuf_wrea = 0;
            end
            @(negedge clk);
            if (bram_en && bram_we) clr++;
            if (bram_en && bram_din == 8'h3C) leak++;
        end
        fbuf_en_wr = 0; fbuf_wrea = 0;
        chk("t4_clear_writes", 32'(clr), 32'd32);
        chk("t4_gpu_leak", 32'(leak), 32'd0);
        chk("t4_drop", 32'(drop_cnt), 32'd4);
        chk("t4_busy_held", 32'(fbuf_rst_busy), 32'd1);
        fbuf_rst_req_n = 1;
        @(negedge clk);
        chk("t4_busy_fall", 32'(fbuf_rst_busy), 32'd0);

        // 5: reset at sweep address 10, sweep restarts from 0
        fbuf_rst_req_n = 0;
        @(negedge clk);
        fbuf_rst_req_n = 1;
        n = 0;
        while (!(bram_en && bram_addr == 8'd10) && n < 100) begin @(negedge clk); n++; end
        chk("t5_reached_10", 32'(bram_addr), 32'd10);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_en", 32'(bram_en), 32'd0);
        chk("t5_rst_addr", 32'(bram_addr), 32'd0);
        chk("t5_rst_din", 32'(bram_din), 32'd0);
        chk("t5_rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("t5_restart_addr", 32'(bram_addr), 32'd0);
        chk("t5_restart_en", 32'(bram_en), 32'd1);
        wait_idle("t5");
        @(negedge clk);

        // 6: write and request in the same IDLE cycle
        fbuf_en_wr = 1; fbuf_wrea = 1; fbuf_addr = 8'd9; fbuf_data = 8'h5A; fbuf_rst_req_n = 0;
        @(negedge clk);
        chk("t6_fwd_addr", 32'(bram_addr), 32'd9);
        chk("t6_fwd_din", 32'(bram_din), 32'h5A);
        chk("t6_fwd_we", 32'(bram_we), 32'd1);
        chk("t6_busy", 32'(fbuf_rst_busy), 32'd1);
        fbuf_en_wr = 0; fbuf_wrea = 0; fbuf_rst_req_n = 1;
        @(negedge clk);
        chk("t6_clr_addr", 32'(bram_addr), 32'd0);
        chk("t6_clr_din", 32'(bram_din), 32'hA5);
        wait_idle("t6");
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
